vga_sprite_disp: RTL

- Parametrised successor of the fixed 640x480 picture display.
- Generates VGA timing from parameters and drives an external synchronous image ROM.
- Overlays one IMG_W x IMG_H sprite on a programmable background at a static or self-bouncing position, or shows colour bars.
- Sits between the pixel-clock domain (PLL output) and the VGA DAC pins.

---
 rtl/vga_sprite_disp_if.sv | 28 ++
 rtl/vga_sprite_disp.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_disp_if.sv
// Pixel-domain bundle between the sprite display, its image ROM and the VGA DAC pins.
// slave = display core, master = surrounding environment (mode/position control, ROM, DAC).
interface vga_sprite_disp_if #(
  parameter int ADDR_W = 12,
  parameter int PIX_W  = 24
);
  logic [1:0]        mode;
  logic [10:0]       pos_x;
  logic [10:0]       pos_y;
  logic [PIX_W-1:0]  bg_color;
  logic [ADDR_W-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_data;
  logic              hsync;
  logic              vsync;
  logic              de;
  logic [PIX_W-1:0]  rgb;
  logic              frame_start;

  modport slave (
    input  mode, pos_x, pos_y, bg_color, rom_data,
    output rom_addr, hsync, vsync, de, rgb, frame_start
  );

  modport master (
    output mode, pos_x, pos_y, bg_color, rom_data,
    input  rom_addr, hsync, vsync, de, rgb, frame_start
  );
endinterface

// File: rtl/vga_sprite_disp.sv
// VGA raster generator overlaying one ROM sprite (static or bouncing), colour bars or flat background.
// Latency: raster counters -> rom_addr 1 clk, -> hsync/vsync/de/rgb/frame_start 3 clk; free-running, no backpressure.
module vga_sprite_disp #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int IMG_W    = 48,
  parameter int IMG_H    = 48,
  parameter int ADDR_W   = 12,
  parameter int PIX_W    = 24,
  parameter int STEP     = 1,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  vga_sprite_disp_if.slave vid
);
  localparam int CW      = 12;
  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int CH      = PIX_W / 3;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HA0      = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] HA1      = CW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [CW-1:0] VA0      = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] VA1      = CW'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [CW-1:0] HS_END   = CW'(H_SYNC);
  localparam logic [CW-1:0] VS_END   = CW'(V_SYNC);
  localparam logic [CW-1:0] X_MAX    = CW'(H_ACTIVE - IMG_W);
  localparam logic [CW-1:0] Y_MAX    = CW'(V_ACTIVE - IMG_H);
  localparam logic [CW-1:0] IMG_WC   = CW'(IMG_W);
  localparam logic [CW-1:0] IMG_HC   = CW'(IMG_H);
  localparam logic [CW-1:0] STEP_C   = CW'(STEP);
  localparam logic [CW-1:0] BAR_LAST = CW'(H_ACTIVE / 8 - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {SEL_BG, SEL_ROM, SEL_BAR} sel_t;

  logic [CW-1:0]     h_cnt, v_cnt, ox, oy, bx, by, bar_pix;
  logic              dx, dy;
  logic [1:0]        mode_r;
  logic [2:0]        bar_idx;
  logic [ADDR_W-1:0] addr_cnt;

  logic              frame_bound, h_act, v_act, hit;
  logic [CW-1:0]     x, y, pos_xc, pos_yc, bx_nx, by_nx;
  logic              dx_nx, dy_nx;
  sel_t              sel;

  logic              s1_de, s1_hs, s1_vs, s1_fs;
  logic              s2_de, s2_hs, s2_vs, s2_fs;
  sel_t              s1_sel, s2_sel;
  logic [2:0]        s1_bar, s2_bar;
  logic [PIX_W-1:0]  bar_rgb;

  always_comb begin
    frame_bound = (h_cnt == '0) && (v_cnt == '0);
    h_act  = (h_cnt >= HA0) && (h_cnt < HA1);
    v_act  = (v_cnt >= VA0) && (v_cnt < VA1);
    x      = h_cnt - HA0;
    y      = v_cnt - VA0;
    hit    = h_act && v_act && (x >= ox) && (x < ox + IMG_WC) && (y >= oy) && (y < oy + IMG_HC);
    pos_xc = ({1'b0, vid.pos_x} > X_MAX) ? X_MAX : {1'b0, vid.pos_x};
    pos_yc = ({1'b0, vid.pos_y} > Y_MAX) ? Y_MAX : {1'b0, vid.pos_y};

    // A step that would leave the range parks on the limit and reverses.
    bx_nx = bx;
    dx_nx = dx;
    if (!dx) begin
      if (bx + STEP_C > X_MAX) begin bx_nx = X_MAX; dx_nx = 1'b1; end
      else bx_nx = bx + STEP_C;
    end else if (bx < STEP_C) begin bx_nx = '0; dx_nx = 1'b0; end
    else bx_nx = bx - STEP_C;

    by_nx = by;
    dy_nx = dy;
    if (!dy) begin
      if (by + STEP_C > Y_MAX) begin by_nx = Y_MAX; dy_nx = 1'b1; end
      else by_nx = by + STEP_C;
    end else if (by < STEP_C) begin by_nx = '0; dy_nx = 1'b0; end
    else by_nx = by - STEP_C;

    sel = SEL_BG;
    if (mode_r == 2'd2) sel = SEL_BAR;
    else if (!mode_r[1] && hit) sel = SEL_ROM;

    // Bar order white..black maps to R=~b1, G=~b2, B=~b0.
    bar_rgb = {{CH{~s2_bar[1]}}, {CH{~s2_bar[2]}}, {CH{~s2_bar[0]}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      mode_r   <= 2'd0;
      ox       <= '0;
      oy       <= '0;
      bx       <= '0;
      by       <= '0;
      dx       <= 1'b0;
      dy       <= 1'b0;
      addr_cnt <= '0;
      bar_pix  <= '0;
      bar_idx  <= 3'd0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end

      // The bounce registers step only at boundaries opening a bouncing frame.
      if (frame_bound) begin
        mode_r   <= vid.mode;
        addr_cnt <= '0;
        if (vid.mode == 2'd1) begin
          ox <= bx;
          oy <= by;
          bx <= bx_nx;
          by <= by_nx;
          dx <= dx_nx;
          dy <= dy_nx;
        end else begin
          ox <= pos_xc;
          oy <= pos_yc;
        end
      end else if (hit && (addr_cnt != ADDR_LAST)) begin
        addr_cnt <= addr_cnt + 1'b1;
      end

      if (!h_act) begin
        bar_pix <= '0;
        bar_idx <= 3'd0;
      end else if (bar_pix == BAR_LAST) begin
        bar_pix <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 1'b1;
      end else begin
        bar_pix <= bar_pix + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vid.rom_addr    <= '0;
      s1_de           <= 1'b0;
      s1_hs           <= ~SYNC_POL;
      s1_vs           <= ~SYNC_POL;
      s1_fs           <= 1'b0;
      s1_sel          <= SEL_BG;
      s1_bar          <= 3'd0;
      s2_de           <= 1'b0;
      s2_hs           <= ~SYNC_POL;
      s2_vs           <= ~SYNC_POL;
      s2_fs           <= 1'b0;
      s2_sel          <= SEL_BG;
      s2_bar          <= 3'd0;
      vid.hsync       <= ~SYNC_POL;
      vid.vsync       <= ~SYNC_POL;
      vid.de          <= 1'b0;
      vid.rgb         <= '0;
      vid.frame_start <= 1'b0;
    end else begin
      if (hit) vid.rom_addr <= addr_cnt;
      s1_de  <= h_act && v_act;
      s1_hs  <= (h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
      s1_vs  <= (v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
      s1_fs  <= frame_bound;
      s1_sel <= sel;
      s1_bar <= bar_idx;

      // Stage 2 lines up with rom_data for the address issued in stage 1.
      s2_de  <= s1_de;
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
      s2_fs  <= s1_fs;
      s2_sel <= s1_sel;
      s2_bar <= s1_bar;

      vid.hsync       <= s2_hs;
      vid.vsync       <= s2_vs;
      vid.de          <= s2_de;
      vid.frame_start <= s2_fs;
      if (!s2_de) begin
        vid.rgb <= '0;
      end else begin
        case (s2_sel)
          SEL_ROM: vid.rgb <= vid.rom_data;
          SEL_BAR: vid.rgb <= bar_rgb;
          default: vid.rgb <= vid.bg_color;
        endcase
      end
    end
  end
endmodule
